// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents:
//   fetch_state_e  - fetch FSM state encoding (IDLE / RUN / HALT)
//   NOP_INSTR      - instruction word used for pipeline bubbles (sll $0,$0,0)
//   ifid_t         - IF/ID pipeline register payload {pc4, instr, valid}
//   IFID_BUBBLE    - IF/ID value representing a bubble
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// 32-bit saturating event counter with synchronous clear.
// Ports:
//   clk_i  - clock
//   clr_i  - synchronous clear, wins over inc_i
//   inc_i  - count one event on this edge
//   cnt_o  - current count; sticks at 32'hFFFF_FFFF
module sat_counter (
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != 32'hFFFF_FFFF)) begin
      cnt_o <= cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// loads the IF/ID pipeline register. Handles hazard stalls, ID-stage
// redirects and halts once fetch runs past the end of instruction memory.
//
// Optional build macro IF_PERF_CNT_EN adds saturating stall/flush event
// counters; without it both counter outputs are tied to zero.
//
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   start_i               - fetch enable (level)
//   stall_i               - hold PC and IF/ID
//   redirect_i/_pc_i      - load new PC and flush IF/ID
//   imem_instr_i          - instruction read combinationally at imem_addr_o
//   imem_addr_o, pc_o     - current PC
//   ifid_pc4_o/instr_o/valid_o - IF/ID register contents
//   halted_o              - fetch has run past the end of memory
//   stall_cnt_o/flush_cnt_o - event counters (zero unless IF_PERF_CNT_EN)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; PC held, IF/ID bubble, waiting for start_i
// RUN   | fetching: redirect > stall/!start hold > sequential fetch
// HALT  | ran past end of memory; bubbles until in-range redirect
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       IMEM_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic [31:0]       imem_instr_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] ifid_pc4_o,
  output logic [31:0]       ifid_instr_o,
  output logic              ifid_valid_o,
  output logic              halted_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  // One extra bit so the byte limit is representable even when it equals 2^ADDR_W.
  localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W+1)'(IMEM_WORDS) << 2;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  ifid_t             ifid_q, ifid_d;
  logic              fetch_past_end;
  logic              redirect_in_range;

  // Wraps modulo 2^ADDR_W; the wrapped value is what gets range-checked.
  assign pc_plus4          = pc_q + ADDR_W'(4);
  assign fetch_past_end    = ({1'b0, pc_plus4} >= PC_LIMIT);
  assign redirect_in_range = ({1'b0, redirect_pc_i} < PC_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (!redirect_i && !stall_i && start_i && fetch_past_end) state_d = HALT;
      HALT:    if (redirect_i && redirect_in_range) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    case (state_q)
      RUN: begin
        if (redirect_i) begin
          pc_d   = redirect_pc_i;
          ifid_d = IFID_BUBBLE;
        end else if (!stall_i && start_i) begin
          // The last in-range instruction is still captured when entering HALT.
          pc_d         = pc_plus4;
          ifid_d.pc4   = 32'(pc_plus4);
          ifid_d.instr = imem_instr_i;
          ifid_d.valid = 1'b1;
        end
      end
      HALT: begin
        ifid_d = IFID_BUBBLE;
        if (redirect_i && redirect_in_range) pc_d = redirect_pc_i;
      end
      default: ;
    endcase
  end

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_pc4_o   = ADDR_W'(ifid_q.pc4);
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_valid_o = ifid_q.valid;
  assign halted_o     = (state_q == HALT);

`ifdef IF_PERF_CNT_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = (state_q == RUN) && stall_i && !redirect_i;
  assign flush_evt = ((state_q == RUN) && redirect_i) ||
                     ((state_q == HALT) && redirect_i && redirect_in_range);

  sat_counter u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (stall_evt),
    .cnt_o (stall_cnt_o)
  );

  sat_counter u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (flush_evt),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = 32'h0;
  assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [63:0] LIM_B = 64'd1024;  // 256 words
  localparam logic [63:0] LIM_S = 64'd16;    // 4 words

  logic        clk;
  logic        rst, start, stall, redir;
  logic [31:0] rpc;

  logic [31:0] instr_b, addr_b, pc_b, pc4_b, iins_b, sc_b, fc_b;
  logic        v_b, h_b;
  logic [31:0] instr_s, addr_s, pc_s, pc4_s, iins_s, sc_s, fc_s;
  logic        v_s, h_s;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr_b = (addr_b < 32'd1024) ? mem[addr_b[9:2]] : (addr_b ^ 32'hA5A5_0000);
  assign instr_s = (addr_s < 32'd1024) ? mem[addr_s[9:2]] : (addr_s ^ 32'hA5A5_0000);

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .IMEM_WORDS(256)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .redirect_i(redir), .redirect_pc_i(rpc), .imem_instr_i(instr_b),
    .imem_addr_o(addr_b), .pc_o(pc_b), .ifid_pc4_o(pc4_b), .ifid_instr_o(iins_b),
    .ifid_valid_o(v_b), .halted_o(h_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
  );

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .IMEM_WORDS(4)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .redirect_i(redir), .redirect_pc_i(rpc), .imem_instr_i(instr_s),
    .imem_addr_o(addr_s), .pc_o(pc_s), .ifid_pc4_o(pc4_s), .ifid_instr_o(iins_s),
    .ifid_valid_o(v_s), .halted_o(h_s), .stall_cnt_o(sc_s), .flush_cnt_o(fc_s)
  );

  // Reference model: architectural view (PC, IF/ID contents, running/halted flags).
  typedef struct {
    logic [31:0] pc, pc4, instr, sc, fc;
    bit          valid, running, halted;
  } mdl_t;

  mdl_t mb, ms;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:2]];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit r, s, st, rd,
                                 input logic [31:0] tgt, input logic [63:0] lim);
    mdl_t n;
    logic [31:0] np;
    n  = m;
    np = m.pc + 32'd4;
    if (r) begin
      n.pc = 0; n.pc4 = 0; n.instr = 0; n.sc = 0; n.fc = 0;
      n.valid = 0; n.running = 0; n.halted = 0;
    end else if (m.halted) begin
      n.pc4 = 0; n.instr = 0; n.valid = 0;
      if (rd && (64'(tgt) < lim)) begin
        n.halted = 0; n.running = 1; n.pc = tgt; n.fc = sat(m.fc);
      end
    end else if (!m.running) begin
      if (s) n.running = 1;
    end else if (rd) begin
      n.pc = tgt; n.pc4 = 0; n.instr = 0; n.valid = 0; n.fc = sat(m.fc);
    end else if (st) begin
      n.sc = sat(m.sc);
    end else if (s) begin
      n.pc4 = np; n.instr = imem(m.pc); n.valid = 1; n.pc = np;
      if (64'(np) >= lim) begin
        n.running = 0; n.halted = 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag, input mdl_t m,
                           input logic [31:0] pc, a, p4, ins, input logic v, h,
                           input logic [31:0] sc, fc);
    chk({tag, ".pc"},    pc, m.pc);
    chk({tag, ".addr"},  a,  m.pc);
    chk({tag, ".pc4"},   p4, m.pc4);
    chk({tag, ".instr"}, ins, m.instr);
    chk({tag, ".valid"}, 32'(v), 32'(m.valid));
    chk({tag, ".halt"},  32'(h), 32'(m.halted));
    chk({tag, ".scnt"},  sc, PERF ? m.sc : 32'h0);
    chk({tag, ".fcnt"},  fc, PERF ? m.fc : 32'h0);
  endtask

  task automatic apply(input bit r, s, st, rd, input logic [31:0] tgt);
    rst = r; start = s; stall = st; redir = rd; rpc = tgt;
    mb = mstep(mb, r, s, st, rd, tgt, LIM_B);
    ms = mstep(ms, r, s, st, rd, tgt, LIM_S);
    @(posedge clk);
    #1;
    chk_model("big", mb, pc_b, addr_b, pc4_b, iins_b, v_b, h_b, sc_b, fc_b);
    chk_model("small", ms, pc_s, addr_s, pc4_s, iins_s, v_s, h_s, sc_s, fc_s);
  endtask

  typedef struct {
    bit          r, s, st, rd;
    logic [31:0] tgt, pc, pc4, instr;
    bit          v, h;
    logic [31:0] sc, fc;
  } vec_t;

  vec_t tv[15];

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
    mb = '{pc: 0, pc4: 0, instr: 0, sc: 0, fc: 0, valid: 0, running: 0, halted: 0};
    ms = mb;
    for (int i = 0; i < 256; i++) mem[i] = (i < 32) ? (32'hA000_0000 + 32'(i)) : $urandom;

    //           r s st rd tgt     pc      pc4     instr         v h sc fc
    tv[0]  = '{1,0,0,0, 32'h0,  32'h0,  32'h0,  32'h0,        0,0, 0,0};
    tv[1]  = '{1,0,0,0, 32'h0,  32'h0,  32'h0,  32'h0,        0,0, 0,0};
    tv[2]  = '{0,1,0,0, 32'h0,  32'h0,  32'h0,  32'h0,        0,0, 0,0};
    tv[3]  = '{0,1,0,0, 32'h0,  32'h4,  32'h4,  32'hA000_0000,1,0, 0,0};
    tv[4]  = '{0,1,0,0, 32'h0,  32'h8,  32'h8,  32'hA000_0001,1,0, 0,0};
    tv[5]  = '{0,1,1,0, 32'h0,  32'h8,  32'h8,  32'hA000_0001,1,0, 1,0};
    tv[6]  = '{0,1,1,0, 32'h0,  32'h8,  32'h8,  32'hA000_0001,1,0, 2,0};
    tv[7]  = '{0,1,1,0, 32'h0,  32'h8,  32'h8,  32'hA000_0001,1,0, 3,0};
    tv[8]  = '{0,1,0,0, 32'h0,  32'hC,  32'hC,  32'hA000_0002,1,0, 3,0};
    tv[9]  = '{0,1,1,1, 32'h40, 32'h40, 32'h0,  32'h0,        0,0, 3,1};
    tv[10] = '{1,1,1,1, 32'h80, 32'h0,  32'h0,  32'h0,        0,0, 0,0};
    tv[11] = '{0,0,0,0, 32'h0,  32'h0,  32'h0,  32'h0,        0,0, 0,0};
    tv[12] = '{0,1,0,0, 32'h0,  32'h0,  32'h0,  32'h0,        0,0, 0,0};
    tv[13] = '{0,1,0,1, 32'h41, 32'h41, 32'h0,  32'h0,        0,0, 0,1};
    tv[14] = '{0,1,0,0, 32'h0,  32'h45, 32'h45, 32'hA000_0010,1,0, 0,1};

    for (int i = 0; i < 15; i++) begin
      apply(tv[i].r, tv[i].s, tv[i].st, tv[i].rd, tv[i].tgt);
      chk($sformatf("vec%0d.pc", i),    pc_b,   tv[i].pc);
      chk($sformatf("vec%0d.pc4", i),   pc4_b,  tv[i].pc4);
      chk($sformatf("vec%0d.instr", i), iins_b, tv[i].instr);
      chk($sformatf("vec%0d.valid", i), 32'(v_b), 32'(tv[i].v));
      chk($sformatf("vec%0d.halt", i),  32'(h_b), 32'(tv[i].h));
      chk($sformatf("vec%0d.scnt", i),  sc_b, PERF ? tv[i].sc : 32'h0);
      chk($sformatf("vec%0d.fcnt", i),  fc_b, PERF ? tv[i].fc : 32'h0);
    end

    // End of memory on the 4-word instance.
    apply(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) apply(0, 1, 0, 0, 32'h0);
    chk("eom.pc", pc_s, 32'h10);
    chk("eom.pc4", pc4_s, 32'h10);
    chk("eom.instr", iins_s, 32'hA000_0003);
    chk("eom.valid", 32'(v_s), 32'h1);
    chk("eom.halt", 32'(h_s), 32'h1);
    apply(0, 1, 0, 0, 32'h0);
    chk("eom.bubble_valid", 32'(v_s), 32'h0);
    chk("eom.bubble_pc", pc_s, 32'h10);
    chk("eom.halt_held", 32'(h_s), 32'h1);
    apply(0, 1, 0, 1, 32'h100);
    chk("eom.oor_pc", pc_s, 32'h10);
    chk("eom.oor_halt", 32'(h_s), 32'h1);
    chk("eom.oor_fcnt", fc_s, 32'h0);
    apply(0, 1, 0, 1, 32'h0);
    chk("eom.resume_pc", pc_s, 32'h0);
    chk("eom.resume_halt", 32'(h_s), 32'h0);
    chk("eom.resume_fcnt", fc_s, PERF ? 32'h1 : 32'h0);
    apply(0, 1, 0, 0, 32'h0);
    chk("eom.refetch_pc4", pc4_s, 32'h4);
    chk("eom.refetch_instr", iins_s, 32'hA000_0000);
    chk("eom.refetch_valid", 32'(v_s), 32'h1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      case ($urandom_range(0, 3))
        0:       t = 32'($urandom_range(0, 20)) * 32'd4;
        1:       t = 32'd1024 - 32'd4 * 32'($urandom_range(1, 4));
        2:       t = $urandom;
        default: t = 32'($urandom_range(0, 15));
      endcase
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
